serial_bit_tx: RTL and testbench
================================

# serial_bit_tx

Parallel-to-serial bit transmitter: accepts a DATA_W-bit word on a load/ready handshake and drives it onto a single-bit line. Each word goes out as one frame: a start bit, the data bits LSB first, then a stop bit. Each bit is held for CLKS_PER_BIT clocks. The block is the sending end of the team's serial bit link; the downstream end samples `tx` with flip-flop-based capture logic.

## Interface
- DATA_W, 8, width of the parallel word (>= 1)
- CLKS_PER_BIT, 4, clocks each bit is held on `tx` (>= 1)

- clk  input  1  clock; all state changes on posedge
- reset  input  1  asynchronous, active-high reset
- data_in  input  DATA_W  word to transmit, sampled on the accept edge only
- load  input  1  request to transmit `data_in`
- ready  output  1  high when the block can accept a word (state IDLE)
- tx  output  1  serial line, registered; idles high
- busy  output  1  high while a frame is in progress (not IDLE)
- done  output  1  one-cycle pulse after the stop bit completes

## Operation
- Reset is asynchronous, active-high, and fixed as such. While `reset` is high:
  - state=IDLE, tx=1, ready=1, busy=0, done=0
  - bit counter and clock counter are 0; shift register is 0
  - `load` is ignored.
- FSM states are IDLE, START, DATA and STOP.
- **Accept:** `load` && `ready` at a posedge (the accept edge E).
  - Latch `data_in` into the shift register.
  - Go to START; tx<=0, ready<=0, busy<=1.
- **Ignored loads:** `load` while not ready is ignored, with no queuing. Changes on `data_in` after E do not affect the frame.
- **START:** hold tx=0 for CLKS_PER_BIT clocks, then go to DATA with tx<=data bit 0.
- **DATA:** each bit is held CLKS_PER_BIT clocks, LSB first. After bit DATA_W-1, go to STOP with tx<=1.
- **STOP:** hold tx=1 for CLKS_PER_BIT clocks, then go to IDLE.
  - ready<=1, busy<=0, done<=1 for exactly one cycle.
- **Back-to-back:** `load` asserted in the cycle `done` is high is accepted at the next edge. `tx` is high for that one cycle between frames.
- **Counters:**
  - The clock counter is $clog2(CLKS_PER_BIT) bits wide (min 1) and counts 0..CLKS_PER_BIT-1, then wraps.
  - The bit counter is $clog2(DATA_W) bits wide (min 1) and counts 0..DATA_W-1.
  - With CLKS_PER_BIT=1, each bit lasts exactly one clock.
- **Reset mid-frame:** the frame is abandoned immediately. `tx` returns to 1 without waiting for a clock edge, and no `done` pulse is produced.

## Timing
Let E be the accept edge, C = CLKS_PER_BIT and N = DATA_W.
- The start bit (tx=0) is on the line from E to E+C.
- Data bit k is on the line from E+(k+1)·C to E+(k+2)·C.
- The stop bit (tx=1) is on the line from E+(N+1)·C to E+(N+2)·C.
- At edge E+(N+2)·C: ready=1, busy=0, done=1. `done` is cleared at the next edge.
- The frame is (N+2)·C clocks long. The minimum accept-to-accept spacing is (N+2)·C+1 clocks.
- `ready` is low from E through E+(N+2)·C.
- `tx`, `ready`, `busy` and `done` are all driven from registers and have no combinational path from inputs.

## Test plan
Defaults: DATA_W=8, CLKS_PER_BIT=4.
- **Reset values:** assert reset for 3 cycles, then release. Required: tx=1, ready=1, busy=0, done=0; no `tx` toggle for 10 idle cycles.
- **Single frame:** load 0xA5 for one cycle. Required: `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks. `done` pulses once, 40 clocks after E; `ready` is low for those 40 clocks.
- **Back-to-back:** load 0x00, then load 0xFF during the `done` cycle.
  - First frame: 0, eight 0s, 1.
  - Then exactly 1 idle-high cycle.
  - Second frame: 0, eight 1s, 1.
  - `done` pulses twice.
- **Load while busy:** load 0x3C, then assert load with data_in=0x99 at cycles 5 and 20 after E. Required: only 0x3C is serialized (0,0,0,1,1,1,1,0,0,1) and only one `done` pulse.
- **Reset mid-frame:** assert reset asynchronously (between clock edges) during data bit 3. Required:
  - `tx` goes to 1 before the next edge.
  - No `done` pulse.
  - After release, load 0x5A produces a correct full frame.
- **CLKS_PER_BIT=1, DATA_W=4:** load 0x9. Required: tx = 0,1,0,0,1,1, one clock each; `done` 6 clocks after E.

Source files
------------

// File: rtl/serial_bit_tx_if.sv
// Load/ready handshake bundle for the serial bit transmitter.
// The master supplies words; the slave (transmitter) reports its status.
interface serial_bit_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              busy;
  logic              done;

  modport master (output data_in, load, input ready, busy, done);
  modport slave  (input data_in, load, output ready, busy, done);
endinterface

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each bit held CLKS_PER_BIT clocks. All outputs come straight from registers.
//
// state | meaning
// IDLE  | line high, ready for a word
// START | start bit (low) on the line
// DATA  | data bits shifting out LSB first
// STOP  | stop bit (high) on the line
module serial_bit_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  serial_bit_tx_if.slave  bus,
  output logic            tx
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic              last_clk;
  logic [DATA_W-1:0] sh_next;

  assign last_clk = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign sh_next  = shreg >> 1;

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  // Async reset drives tx high immediately, abandoning any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            shreg   <= bus.data_in;
            clk_cnt <= '0;
            bit_cnt <= '0;
            tx      <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (last_clk) begin
            clk_cnt <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        DATA: begin
          if (last_clk) begin
            clk_cnt <= '0;
            if (bit_cnt == BW'(DATA_W - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= sh_next;
              tx      <= sh_next[0];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        STOP: begin
          if (last_clk) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        default: begin
          tx      <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: table of known frames, hand-written reset corner,
// then random frames against a frame-building reference model.
module tb_serial_bit_tx;
  logic clk = 1'b0;
  logic reset;
  logic tx_a;
  logic tx_b;

  serial_bit_tx_if #(.DATA_W(8)) ifa ();
  serial_bit_tx_if #(.DATA_W(4)) ifb ();

  serial_bit_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave),
    .tx    (tx_a)
  );

  serial_bit_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave),
    .tx    (tx_b)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit         sel;
    logic [7:0] data;
    logic [9:0] frame;
    bit         junk;
    bit         chain;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic ld, input logic [7:0] d);
    if (sel) begin
      ifb.load    = ld;
      ifb.data_in = d[3:0];
    end else begin
      ifa.load    = ld;
      ifa.data_in = d;
    end
  endtask

  function automatic logic [3:0] flags(input bit sel);
    if (sel) return {tx_b, ifb.ready, ifb.busy, ifb.done};
    return {tx_a, ifa.ready, ifa.busy, ifa.done};
  endfunction

  task automatic idle_check(input int n);
    bit ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (flags(1'b0) !== 4'b1100 || flags(1'b1) !== 4'b1100) ok = 1'b0;
      @(negedge clk);
    end
    check("idle", 64'(ok), 64'd1);
  endtask

  // Starts at a negedge; loads d, samples every cycle of the frame and the done cycle.
  task automatic run_frame(input bit sel, input logic [7:0] d, input logic [9:0] frame,
                           input bit junk, input bit chain);
    int c   = sel ? 1 : 4;
    int n   = sel ? 4 : 8;
    int len = (n + 2) * c;
    logic [39:0] cap  = '0;
    logic [39:0] expw = '0;
    logic [3:0]  f;
    bit rb_ok = 1'b1;
    bit early = 1'b0;
    for (int i = 0; i < len; i++) expw[i] = frame[i / c];
    drive(sel, 1'b1, d);
    @(negedge clk);
    drive(sel, 1'b0, 8'($urandom));
    for (int i = 0; i < len; i++) begin
      f = flags(sel);
      cap[i] = f[3];
      if (f[2:1] !== 2'b01) rb_ok = 1'b0;
      if (f[0] !== 1'b0) early = 1'b1;
      if (junk && (i == 4 || i == 19)) drive(sel, 1'b1, 8'h99);
      else drive(sel, 1'b0, 8'($urandom));
      @(negedge clk);
    end
    check("frame_tx", 64'(cap), 64'(expw));
    check("frame_ready_busy", 64'(rb_ok), 64'd1);
    check("done_early", 64'(early), 64'd0);
    check("done_end", 64'(flags(sel)), 64'b1101);
    if (!chain) @(negedge clk);
  endtask

  initial begin
    bit         sel;
    logic [7:0] d;
    logic [9:0] frame;
    int         gap;
    bit         junk;

    vecs[0] = '{1'b0, 8'hA5, 10'b1101001010, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 10'b1000000000, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'hFF, 10'b1111111110, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h3C, 10'b1001111000, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h09, 10'b0000110010, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'hC3, 10'b1110000110, 1'b0, 1'b0};

    reset = 1'b1;
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b1, 1'b1, 8'h0F);
    repeat (3) @(negedge clk);
    check("reset_a", 64'(flags(1'b0)), 64'b1100);
    check("reset_b", 64'(flags(1'b1)), 64'b1100);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    reset = 1'b0;
    idle_check(10);

    foreach (vecs[v]) begin
      run_frame(vecs[v].sel, vecs[v].data, vecs[v].frame, vecs[v].junk, vecs[v].chain);
      if (!vecs[v].chain) idle_check(2);
    end

    // Async reset during data bit 3 (samples 16..19) of a 0x00 frame.
    drive(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00);
    repeat (17) @(negedge clk);
    #1;
    check("pre_reset_tx", 64'(tx_a), 64'd0);
    reset = 1'b1;
    #1;
    check("async_reset", 64'(flags(1'b0)), 64'b1100);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle_check(5);
    run_frame(1'b0, 8'h5A, 10'b1010110100, 1'b0, 1'b0);
    idle_check(2);

    for (int r = 0; r < 24; r++) begin
      sel   = 1'($urandom_range(0, 1));
      d     = 8'($urandom);
      junk  = 1'($urandom_range(0, 1));
      gap   = (r == 23) ? 2 : int'($urandom_range(0, 3));
      frame = sel ? {4'b0000, 1'b1, d[3:0], 1'b0} : {1'b1, d, 1'b0};
      run_frame(sel, d, frame, junk, gap == 0);
      if (gap != 0) idle_check(gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
